// File: rtl/regs_pkg.sv
// Shared definitions for the register file: default sizes, PC update
// selector and helpers that locate the hard-wired zero and PC slots.
package regs_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 8;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_WRITE,
        PC_LOAD,
        PC_INC
    } pc_sel_e;

    function automatic int zero_idx();
        return 0;
    endfunction

    function automatic int pc_idx(input int nregs);
        return nregs - 1;
    endfunction

endpackage

// File: rtl/regs_scoreboard.sv
// Pending-write scoreboard: one bit per register address, set on issue and
// cleared on writeback. When both hit the same bit, set wins. Bit 0 is the
// zero register and never becomes pending.
module regs_scoreboard
    import regs_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_v,
    input  logic [AW-1:0] set_a,
    input  logic          clr_v,
    input  logic [AW-1:0] clr_a,
    input  logic [AW-1:0] la_a,
    input  logic [AW-1:0] lb_a,
    output logic          la_busy,
    output logic          lb_busy,
    output logic          any_busy
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_next;

    // Clear first so a simultaneous set on the same address leaves the bit at 1
    always_comb begin
        pend_next = pending;
        if (clr_v) pend_next[clr_a] = 1'b0;
        if (set_v) pend_next[set_a] = 1'b1;
        pend_next[zero_idx()] = 1'b0;
    end

    // Pending bits, cleared asynchronously so busy reads 0 during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pend_next;
    end

    // Combinational lookups of the stored bits
    always_comb begin
        la_busy  = pending[la_a];
        lb_busy  = pending[lb_a];
        any_busy = |pending;
    end

endmodule

// File: rtl/regs_file.sv
// Register file with hard-wired zero at address 0, the PC mapped at the top
// address, two combinational read ports and a pending-write scoreboard.
// Optional macro REGS_FILE_BYPASS_EN forwards same-cycle write data to the
// read ports; without it reads return stored state only.
module regs_file
    import regs_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int PC_STEP = 1,
    localparam int AW     = $clog2(NREGS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     rx_a,
    input  logic [AW-1:0]     ry_a,
    output logic [DATA_W-1:0] rx_d,
    output logic [DATA_W-1:0] ry_d,
    input  logic              pc_inc,
    input  logic              pc_ld,
    input  logic [DATA_W-1:0] pc_nxt,
    input  logic              stall,
    output logic [DATA_W-1:0] pc,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    output logic              rx_busy,
    output logic              ry_busy,
    output logic              any_busy
);

    localparam logic [AW-1:0] ZERO_A = AW'(zero_idx());
    localparam logic [AW-1:0] PC_A   = AW'(pc_idx(NREGS));

    logic [DATA_W-1:0] gpr [1:NREGS-2];
    logic [DATA_W-1:0] rx_stored;
    logic [DATA_W-1:0] ry_stored;
    logic [DATA_W-1:0] pc_next;
    pc_sel_e           pc_sel;
    logic              sb_rx_busy;
    logic              sb_ry_busy;

    // General registers; the zero and PC slots have no storage here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NREGS-2; i++) gpr[i] <= '0;
        end else if (we) begin
            for (int i = 1; i <= NREGS-2; i++) begin
                if (wa == AW'(i)) gpr[i] <= wd;
            end
        end
    end

    // PC source priority: direct write, load, stall, increment, hold
    always_comb begin
        pc_sel = PC_HOLD;
        if (we && wa == PC_A) pc_sel = PC_WRITE;
        else if (pc_ld)       pc_sel = PC_LOAD;
        else if (stall)       pc_sel = PC_HOLD;
        else if (pc_inc)      pc_sel = PC_INC;
    end

    // PC next value; the increment wraps naturally at DATA_W bits
    always_comb begin
        case (pc_sel)
            PC_WRITE: pc_next = wd;
            PC_LOAD:  pc_next = pc_nxt;
            PC_INC:   pc_next = pc + DATA_W'(PC_STEP);
            default:  pc_next = pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= pc_next;
    end

    // Stored-state read mux for both ports; address 0 falls through to zero
    always_comb begin
        rx_stored = '0;
        ry_stored = '0;
        for (int i = 1; i <= NREGS-2; i++) begin
            if (rx_a == AW'(i)) rx_stored = gpr[i];
            if (ry_a == AW'(i)) ry_stored = gpr[i];
        end
        if (rx_a == PC_A) rx_stored = pc;
        if (ry_a == PC_A) ry_stored = pc;
    end

    regs_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_v    (iss_v),
        .set_a    (iss_a),
        .clr_v    (we),
        .clr_a    (wa),
        .la_a     (rx_a),
        .lb_a     (ry_a),
        .la_busy  (sb_rx_busy),
        .lb_busy  (sb_ry_busy),
        .any_busy (any_busy)
    );

`ifdef REGS_FILE_BYPASS_EN
    logic rx_hit;
    logic ry_hit;

    // Forward write data to a matching read port; gated off during reset
    always_comb begin
        rx_hit  = rst_n && we && (wa == rx_a) && (rx_a != ZERO_A);
        ry_hit  = rst_n && we && (wa == ry_a) && (ry_a != ZERO_A);
        rx_d    = rx_hit ? wd : rx_stored;
        ry_d    = ry_hit ? wd : ry_stored;
        rx_busy = rx_hit ? (iss_v && iss_a == rx_a) : sb_rx_busy;
        ry_busy = ry_hit ? (iss_v && iss_a == ry_a) : sb_ry_busy;
    end
`else
    // Reads return stored state only; a same-cycle write is not visible yet
    always_comb begin
        rx_d    = rx_stored;
        ry_d    = ry_stored;
        rx_busy = sb_rx_busy;
        ry_busy = sb_ry_busy;
    end
`endif

endmodule
